// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: data-memory width codes and the queued entry layout.
package sb_pkg;

    localparam logic [3:0] DM_TYPE_WORD = 4'b0001;
    localparam logic [3:0] DM_TYPE_HALF = 4'b0010;
    localparam logic [3:0] DM_TYPE_BYTE = 4'b0100;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  dtype;
        logic [31:0] pc;
    } sb_entry_t;

    // Word-granular address compare used by the load hazard check.
    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store, load-probe and data-memory signals of the store buffer grouped as one bundle.
interface store_buffer_if #(parameter int DEPTH = 4);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic          st_ready;
    logic [31:0]   st_addr;
    logic [31:0]   st_wd;
    logic [3:0]    st_type;
    logic [31:0]   st_pc;

    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic          ld_hazard;
    logic          ld_fwd_valid;
    logic [31:0]   ld_fwd_data;

    logic          dm_busy;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wd;
    logic [3:0]    dm_type;
    logic [31:0]   dm_pc;

    logic [CW-1:0] count;
    logic          empty;

    modport slave (
        input  st_valid, st_addr, st_wd, st_type, st_pc,
        input  ld_valid, ld_addr, dm_busy,
        output st_ready, ld_hazard, ld_fwd_valid, ld_fwd_data,
        output dm_we, dm_addr, dm_wd, dm_type, dm_pc, count, empty
    );

    modport master (
        output st_valid, st_addr, st_wd, st_type, st_pc,
        output ld_valid, ld_addr, dm_busy,
        input  st_ready, ld_hazard, ld_fwd_valid, ld_fwd_data,
        input  dm_we, dm_addr, dm_wd, dm_type, dm_pc, count, empty
    );

endinterface

// File: rtl/store_buffer_match.sv
// Age-ordered compare of a load address against the occupied buffer entries;
// reports whether any entry hits and which one is the youngest hit.
module sb_match
    import sb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  sb_entry_t                  i_entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   i_head,
    input  logic [$clog2(DEPTH):0]     i_count,
    input  logic [31:0]                i_ld_addr,
    output logic                       o_any_hit,
    output logic [$clog2(DEPTH)-1:0]   o_hit_idx,
    output logic [3:0]                 o_hit_type
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] w_idx;

    // Walk from oldest to youngest so the last hit recorded is the youngest.
    always_comb begin
        o_any_hit  = 1'b0;
        o_hit_idx  = i_head;
        o_hit_type = '0;
        w_idx      = i_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PW'(k);
            if ((CW'(k) < i_count) && same_word(i_entries[w_idx].addr, i_ld_addr)) begin
                o_any_hit  = 1'b1;
                o_hit_idx  = w_idx;
                o_hit_type = i_entries[w_idx].dtype;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO draining into data memory when the port is free.
// Build option SB_FWD_EN: forward the youngest aligned word store to a matching load.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    store_buffer_if.slave    sb
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_run;
    logic          w_empty;
    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_probe;
    sb_entry_t     w_new;
    logic          w_any_hit;
    logic [PW-1:0] w_hit_idx;
    logic [3:0]    w_hit_type;

    assign w_run   = reset;
    assign w_empty = (r_count == '0);
    assign w_ready = w_run && (r_count < CW'(DEPTH));
    assign w_push  = sb.st_valid && w_ready;
    assign w_pop   = w_run && !w_empty && !sb.dm_busy;
    assign w_probe = w_run && sb.ld_valid;
    assign w_new   = '{addr: sb.st_addr, wd: sb.st_wd, dtype: sb.st_type, pc: sb.st_pc};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone says which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= w_new;
    end

    sb_match #(.DEPTH(DEPTH)) u_match (
        .i_entries  (r_mem),
        .i_head     (r_head),
        .i_count    (r_count),
        .i_ld_addr  (sb.ld_addr),
        .o_any_hit  (w_any_hit),
        .o_hit_idx  (w_hit_idx),
        .o_hit_type (w_hit_type)
    );

    assign sb.st_ready = w_ready;
    assign sb.dm_we    = w_pop;
    assign sb.dm_addr  = w_run ? r_mem[r_head].addr  : '0;
    assign sb.dm_wd    = w_run ? r_mem[r_head].wd    : '0;
    assign sb.dm_type  = w_run ? r_mem[r_head].dtype : '0;
    assign sb.dm_pc    = w_run ? r_mem[r_head].pc    : '0;
    assign sb.count    = w_run ? r_count : '0;
    assign sb.empty    = !w_run || w_empty;

`ifdef SB_FWD_EN
    logic w_fwd_ok;

    // Only a full aligned word can stand in for memory; anything narrower must stall.
    assign w_fwd_ok        = (w_hit_type == DM_TYPE_WORD) && (r_mem[w_hit_idx].addr[1:0] == 2'b00);
    assign sb.ld_fwd_valid = w_probe && w_any_hit && w_fwd_ok;
    assign sb.ld_fwd_data  = sb.ld_fwd_valid ? r_mem[w_hit_idx].wd : '0;
    assign sb.ld_hazard    = w_probe && w_any_hit && !w_fwd_ok;
`else
    logic w_unused_hit;

    assign w_unused_hit    = ^{w_hit_idx, w_hit_type};
    assign sb.ld_fwd_valid = 1'b0;
    assign sb.ld_fwd_data  = '0;
    assign sb.ld_hazard    = w_probe && w_any_hit;
`endif

endmodule
